// File: rtl/ring_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ring_seq_if                                                    |
// | Purpose  : Bundle between a ring-word source and the ring sequence       |
// |            checker.                                                      |
// | Signals  : ring_in/ring_vld/clr_err  source -> checker                   |
// |            idx/onehot_ok/locked/seq_err/lap_tick/lap_cnt  checker -> src |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface ring_seq_if #(
  parameter int N     = 4,
  parameter int LAP_W = 8
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     ring_in;
  logic             ring_vld;
  logic             clr_err;
  logic [IDX_W-1:0] idx;
  logic             onehot_ok;
  logic             locked;
  logic             seq_err;
  logic             lap_tick;
  logic [LAP_W-1:0] lap_cnt;

  // master: whoever supplies the ring word and observes the verdict
  modport master (
    output ring_in, ring_vld, clr_err,
    input  idx, onehot_ok, locked, seq_err, lap_tick, lap_cnt
  );

  // slave: the checker itself
  modport slave (
    input  ring_in, ring_vld, clr_err,
    output idx, onehot_ok, locked, seq_err, lap_tick, lap_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ring_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ring_seq_checker                                              |
// | Purpose  : Run-time integrity monitor for a rotate-right one-hot ring    |
// |            counter. Decodes the word, checks each step, locks after      |
// |            LOCK_CNT legal steps, flags sticky sequence errors and counts |
// |            laps while locked.                                            |
// | Ports    : clk  - clock (posedge)                                         |
// |            rst  - asynchronous, active-low reset                         |
// |            bus  - ring_seq_if.slave (ring word in, status out)           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ring_seq_checker #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int LAP_W    = 8
) (
  input  wire          clk,
  input  wire          rst,
  ring_seq_if.slave    bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int GC_W  = $clog2(LOCK_CNT + 1);
  localparam logic [N-1:0]  TOP_WORD  = {1'b1, {(N-1){1'b0}}};
  localparam logic [GC_W-1:0] LAST_GC = GC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t            state;
  logic [N-1:0]      prev;
  logic [GC_W-1:0]   good_cnt;

  logic              onehot;
  logic              match;
  logic [N-1:0]      expected;
  logic [IDX_W-1:0]  pos;

  // Word classification and decode of the current ring word
  always_comb begin
    onehot   = (bus.ring_in != '0) &&
               ((bus.ring_in & (bus.ring_in - 1'b1)) == '0);
    expected = {prev[0], prev[N-1:1]};
    match    = (bus.ring_in == expected);
    pos      = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.ring_in[i]) pos = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      prev          <= '0;
      good_cnt      <= '0;
      bus.idx       <= '0;
      bus.onehot_ok <= 1'b0;
      bus.locked    <= 1'b0;
      bus.seq_err   <= 1'b0;
      bus.lap_tick  <= 1'b0;
      bus.lap_cnt   <= '0;
    end else begin
      bus.lap_tick <= 1'b0;
      if (bus.clr_err) begin
        // Clear wins over whatever ring word arrives in the same cycle
        state       <= HUNT;
        good_cnt    <= '0;
        bus.locked  <= 1'b0;
        bus.seq_err <= 1'b0;
        bus.lap_cnt <= '0;
      end else if (bus.ring_vld) begin
        bus.onehot_ok <= onehot;
        if (onehot) begin
          bus.idx <= pos;
          prev    <= bus.ring_in;
        end
        case (state)
          HUNT: begin
            if (onehot) begin
              state    <= TRACK;
              good_cnt <= '0;
            end
          end
          TRACK: begin
            if (match) begin
              if (good_cnt == LAST_GC) begin
                state      <= LOCKED;
                bus.locked <= 1'b1;
                good_cnt   <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else if (onehot) begin
              // Legal word but wrong step: restart tracking from this word
              good_cnt <= '0;
            end else begin
              state    <= HUNT;
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              if (bus.ring_in == TOP_WORD) begin
                bus.lap_tick <= 1'b1;
                bus.lap_cnt  <= bus.lap_cnt + 1'b1;
              end
            end else begin
              state       <= ERR;
              bus.seq_err <= 1'b1;
              bus.locked  <= 1'b0;
            end
          end
          default: begin
            // ERR: sequence checking suspended until clr_err
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ring_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ring_seq_checker                                           |
// | Purpose  : Directed self-checking bench for ring_seq_checker (N=4,       |
// |            LOCK_CNT=3, LAP_W=8).                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ring_seq_checker;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ring_seq_if #(.N(4), .LAP_W(8)) bus ();

  ring_seq_checker #(.N(4), .LOCK_CNT(3), .LAP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_idx, input logic e_ok,
                         input logic e_lk, input logic e_se, input logic e_lt,
                         input logic [7:0] e_lc);
    chk($sformatf("%s.idx", tag),       32'(bus.idx),       32'(e_idx));
    chk($sformatf("%s.onehot_ok", tag), 32'(bus.onehot_ok), 32'(e_ok));
    chk($sformatf("%s.locked", tag),    32'(bus.locked),    32'(e_lk));
    chk($sformatf("%s.seq_err", tag),   32'(bus.seq_err),   32'(e_se));
    chk($sformatf("%s.lap_tick", tag),  32'(bus.lap_tick),  32'(e_lt));
    chk($sformatf("%s.lap_cnt", tag),   32'(bus.lap_cnt),   32'(e_lc));
  endtask

  // Apply one input vector, clock it in, sample 1 time unit after the edge
  task automatic step(input logic [3:0] r, input logic v, input logic c);
    bus.ring_in  = r;
    bus.ring_vld = v;
    bus.clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.ring_in  = 4'b0000;
    bus.ring_vld = 1'b0;
    bus.clr_err  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1) Acquire lock on 1000,0100,0010,0001
    step(4'b1000, 1'b1, 1'b0); chk_all("acq1", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0100, 1'b1, 1'b0); chk_all("acq2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0010, 1'b1, 1'b0); chk_all("acq3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0001, 1'b1, 1'b0); chk_all("acq4", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // 2) First lap, then 255 more laps to wrap the counter to 0
    step(4'b1000, 1'b1, 1'b0); chk_all("lap1", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    step(4'b0100, 1'b1, 1'b0); chk_all("lap1_end", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0); chk_all("lap2", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    for (int k = 3; k <= 256; k++) begin
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0001, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b0);
      chk($sformatf("lapcnt%0d", k), 32'(bus.lap_cnt), 32'(k % 256));
    end
    chk_all("lap_wrap", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);

    // 5) ring_vld low with garbage: everything holds, lap_tick drops
    step(4'b0110, 1'b0, 1'b0); chk_all("hold1", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(4'b1111, 1'b0, 1'b0); chk_all("hold2", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(4'b0000, 1'b0, 1'b0); chk_all("hold3", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(4'b0001, 1'b0, 1'b0); chk_all("hold4", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(4'b1000, 1'b0, 1'b0); chk_all("hold5", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(4'b0100, 1'b1, 1'b0); chk_all("resume", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0); chk_all("resume_lap", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);

    // 3) Illegal step while locked, sticky error, clear, relock
    step(4'b0010, 1'b1, 1'b0); chk_all("err", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    step(4'b0001, 1'b1, 1'b0); chk_all("err_sticky1", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    step(4'b1000, 1'b1, 1'b0); chk_all("err_sticky2", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    step(4'b0100, 1'b1, 1'b1);
    chk("clr.seq_err", 32'(bus.seq_err), 32'd0);
    chk("clr.lap_cnt", 32'(bus.lap_cnt), 32'd0);
    chk("clr.locked",  32'(bus.locked),  32'd0);
    step(4'b0100, 1'b1, 1'b0); chk_all("relock1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0010, 1'b1, 1'b0); chk_all("relock2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0001, 1'b1, 1'b0); chk_all("relock3", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b1000, 1'b1, 1'b0); chk_all("relock4", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // 4) Non-onehot in HUNT, then TRACK jump restarts the legal-step count
    step(4'b0000, 1'b0, 1'b1); chk("clr2.locked", 32'(bus.locked), 32'd0);
    step(4'b0110, 1'b1, 1'b0); chk_all("bad_word", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b1000, 1'b1, 1'b0); chk_all("trk_start", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0100, 1'b1, 1'b0); chk_all("trk_g1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b1000, 1'b1, 1'b0); chk_all("trk_jump", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0100, 1'b1, 1'b0); chk_all("trk_r1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0010, 1'b1, 1'b0); chk_all("trk_r2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'b0001, 1'b1, 1'b0); chk_all("trk_r3", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // 6) Asynchronous reset between edges while locked
    step(4'b1000, 1'b1, 1'b0); chk_all("pre_rst", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    rst = 1'b0;
    #2;
    chk_all("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    // After reset the FSM hunts: lock needs the full four-word acquisition
    step(4'b1000, 1'b1, 1'b0); chk("post_rst1.locked", 32'(bus.locked), 32'd0);
    step(4'b0100, 1'b1, 1'b0); chk("post_rst2.locked", 32'(bus.locked), 32'd0);
    step(4'b0010, 1'b1, 1'b0); chk("post_rst3.locked", 32'(bus.locked), 32'd0);
    step(4'b0001, 1'b1, 1'b0); chk("post_rst4.locked", 32'(bus.locked), 32'd1);
    // clr_err together with an illegal step: clear wins
    step(4'b0010, 1'b1, 1'b1);
    chk("clr_ill.seq_err",  32'(bus.seq_err),  32'd0);
    chk("clr_ill.locked",   32'(bus.locked),   32'd0);
    chk("clr_ill.lap_tick", 32'(bus.lap_tick), 32'd0);
    step(4'b0010, 1'b1, 1'b0);
    chk("hunt_after_clr.seq_err", 32'(bus.seq_err), 32'd0);
    chk("hunt_after_clr.locked",  32'(bus.locked),  32'd0);
    chk("hunt_after_clr.idx",     32'(bus.idx),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
